game_judge: RTL

GAME_JUDGE -- requirements
Module: game_judge

---
 rtl/game_judge.sv | 122 ++++++++++++
 1 files changed

// File: rtl/game_judge.sv
// Game referee: restarts the external win/loss counter, measures per-game progress
// against baselines captured at game start, and keeps saturating session tallies.
module game_judge #(
  parameter logic [3:0] WIN_GOAL  = 4'd3,
  parameter logic [3:0] LOSE_GOAL = 4'd3,
  parameter logic [3:0] START_VAL = 4'd7
) (
  input  logic       dclk,
  input  logic       rst,
  input  logic [3:0] count,
  input  logic [3:0] W_count,
  input  logic [3:0] L_count,
  input  logic       ack,
  output logic       INIT,
  output logic [3:0] inval,
  output logic       GAMEOVER,
  output logic [1:0] WHO,
  output logic [7:0] wins,
  output logic [7:0] losses,
  output logic [7:0] ties
);

  typedef enum logic [1:0] {START, SETTLE, PLAY, OVER} state_e;

  // The goal bits pack directly into the result code: {loss_hit, win_hit}.
  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_WIN  = 2'b01;
  localparam logic [1:0] RES_LOSS = 2'b10;
  localparam logic [1:0] RES_TIE  = 2'b11;

  state_e     state_q, state_d;
  logic       hold_q;
  logic [3:0] w_base_q, w_base_d;
  logic [3:0] l_base_q, l_base_d;
  logic [1:0] who_q, who_d;
  logic [7:0] wins_q, wins_d;
  logic [7:0] losses_q, losses_d;
  logic [7:0] ties_q, ties_d;

  logic [3:0] dw, dl;
  logic [1:0] goal;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // 4-bit subtraction wraps mod 16, so tally roll-over mid-game is harmless.
  assign dw   = W_count - w_base_q;
  assign dl   = L_count - l_base_q;
  assign goal = {dl >= LOSE_GOAL, dw >= WIN_GOAL};

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d  = state_q;
    w_base_d = w_base_q;
    l_base_d = l_base_q;
    who_d    = who_q;
    wins_d   = wins_q;
    losses_d = losses_q;
    ties_d   = ties_q;
    unique case (state_q)
      START:  if (!hold_q) state_d = SETTLE;
      SETTLE: begin
        w_base_d = W_count;
        l_base_d = L_count;
        state_d  = PLAY;
      end
      PLAY: if (goal != RES_NONE) begin
        state_d = OVER;
        who_d   = goal;
        unique case (goal)
          RES_WIN:  wins_d   = sat_inc(wins_q);
          RES_LOSS: losses_d = sat_inc(losses_q);
          RES_TIE:  ties_d   = sat_inc(ties_q);
          default:  ;
        endcase
      end
      OVER: if (ack) begin
        state_d = START;
        who_d   = RES_NONE;
      end
      default: state_d = START;
    endcase
  end

  // hold_q keeps START from pulsing INIT until the first edge with rst low.
  always_ff @(posedge dclk) begin
    if (rst) begin
      state_q  <= START;
      hold_q   <= 1'b1;
      w_base_q <= '0;
      l_base_q <= '0;
      who_q    <= RES_NONE;
      wins_q   <= '0;
      losses_q <= '0;
      ties_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      state_q  <= state_d;
      hold_q   <= 1'b0;
      w_base_q <= w_base_d;
      l_base_q <= l_base_d;
      who_q    <= who_d;
      wins_q   <= wins_d;
      losses_q <= losses_d;
      ties_q   <= ties_d;
    end
  end

  assign INIT     = (state_q == START) && !hold_q;
  assign inval    = START_VAL;
  assign GAMEOVER = (state_q == OVER);
  assign WHO      = who_q;
  assign wins     = wins_q;
  assign losses   = losses_q;
  assign ties     = ties_q;

  // The counter should already hold the load value once START has completed.
  a_settle_count: assert property (@(posedge dclk) disable iff (rst)
    (state_q == SETTLE) |-> (count == START_VAL));

endmodule
